// File: rtl/gbh_pkg.sv
// Shared types and defaults for the speculative global-branch-history controller.
// Holds the FSM state encoding and the checkpoint entry layout.
package gbh_pkg;

    localparam int HIST_W_DEF = 4;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRACK   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    typedef struct packed {
        logic pred_taken;
    } ckpt_t;

endpackage

// File: rtl/gbh_ckpt_fifo.sv
// Checkpoint FIFO: DEPTH x ckpt_t synchronous queue of in-flight branch predictions.
// Latency: pushed entry is visible at head_dat the cycle after the push edge.
// Backpressure: none internally; caller must not push when full or pop when empty. clear wins.
module gbh_ckpt_fifo
    import gbh_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             init,
    input  logic             push,
    input  ckpt_t            push_dat,
    input  logic             pop,
    input  logic             clear,
    output ckpt_t            head_dat,
    output logic [CNT_W-1:0] count
);

    ckpt_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clock or posedge init) begin
        if (init) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push && !clear) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/gbh_spec_ctrl.sv
// Speculative GBH controller: speculative/architectural history, in-order resolve, mispredict recovery.
// Latency: histories, commit strobe and flush all register one edge after the push/resolve.
// Backpressure: pred_ready drops when DEPTH branches are in flight or during the recover cycle.
// Optional: GBH_STATS_EN adds saturating resolve/mispredict counters.
module gbh_spec_ctrl
    import gbh_pkg::*;
#(
    parameter  int HIST_W = HIST_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              init,
    input  logic              pred_valid,
    input  logic              pred_taken,
    output logic              pred_ready,
    input  logic              res_valid,
    input  logic              res_outcome,
    output logic [HIST_W-1:0] spec_hist,
    output logic [HIST_W-1:0] commit_hist,
    output logic              commit_valid,
    output logic              commit_outcome,
    output logic              flush,
`ifdef GBH_STATS_EN
    output logic [15:0]       branch_cnt,
    output logic [15:0]       mispred_cnt,
`endif
    output logic [CNT_W-1:0]  in_flight
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t state;
    state_t state_nxt;
    ckpt_t  head;
    ckpt_t  push_dat;
    logic   push;
    logic   resolve;
    logic   mispredict;

    always_comb begin
        state_nxt  = state;
        pred_ready = (state != RECOVER) && (in_flight < DEPTH_C);
        resolve    = res_valid && (state == TRACK);
        mispredict = resolve && (head.pred_taken != res_outcome);
        // A prediction issued alongside a mispredict is on the wrong path.
        push       = pred_valid && pred_ready && !mispredict;
        push_dat   = '{pred_taken: pred_taken};
        case (state)
            IDLE: begin
                if (push) state_nxt = TRACK;
            end
            TRACK: begin
                if (mispredict)
                    state_nxt = RECOVER;
                else if (resolve && !push && (in_flight == ONE_C))
                    state_nxt = IDLE;
            end
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge init) begin
        if (init) begin
            state          <= IDLE;
            spec_hist      <= '0;
            commit_hist    <= '0;
            commit_valid   <= 1'b0;
            commit_outcome <= 1'b0;
        end else begin
            state          <= state_nxt;
            commit_valid   <= resolve;
            commit_outcome <= resolve & res_outcome;
            if (resolve) commit_hist <= {commit_hist[HIST_W-2:0], res_outcome};
            // Recovery restarts speculation from the just-updated architectural history.
            if (mispredict)
                spec_hist <= {commit_hist[HIST_W-2:0], res_outcome};
            else if (push)
                spec_hist <= {spec_hist[HIST_W-2:0], pred_taken};
        end
    end

    assign flush = (state == RECOVER);

`ifdef GBH_STATS_EN
    always_ff @(posedge clock or posedge init) begin
        if (init) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (resolve && (branch_cnt != 16'hFFFF))     branch_cnt  <= branch_cnt + 16'd1;
            if (mispredict && (mispred_cnt != 16'hFFFF)) mispred_cnt <= mispred_cnt + 16'd1;
        end
    end
`endif

    gbh_ckpt_fifo #(.DEPTH(DEPTH)) u_ckpt_fifo (
        .clock    (clock),
        .init     (init),
        .push     (push),
        .push_dat (push_dat),
        .pop      (resolve),
        .clear    (mispredict),
        .head_dat (head),
        .count    (in_flight)
    );

endmodule

// File: tb/tb_gbh_spec_ctrl.sv
// Bench for gbh_spec_ctrl (HIST_W=4, DEPTH=4): queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_gbh_spec_ctrl;

    logic       clock = 1'b0;
    logic       init;
    logic       pred_valid = 1'b0;
    logic       pred_taken = 1'b0;
    logic       pred_ready;
    logic       res_valid = 1'b0;
    logic       res_outcome = 1'b0;
    logic [3:0] spec_hist;
    logic [3:0] commit_hist;
    logic       commit_valid;
    logic       commit_outcome;
    logic       flush;
    logic [2:0] in_flight;
`ifdef GBH_STATS_EN
    logic [15:0] branch_cnt;
    logic [15:0] mispred_cnt;
`endif

    int checks = 0;
    int errors = 0;

    gbh_spec_ctrl #(.HIST_W(4), .DEPTH(4)) dut (
        .clock          (clock),
        .init           (init),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_ready     (pred_ready),
        .res_valid      (res_valid),
        .res_outcome    (res_outcome),
        .spec_hist      (spec_hist),
        .commit_hist    (commit_hist),
        .commit_valid   (commit_valid),
        .commit_outcome (commit_outcome),
        .flush          (flush),
`ifdef GBH_STATS_EN
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt),
`endif
        .in_flight      (in_flight)
    );

    always #5 clock = ~clock;

    // Reference model: a queue of in-flight predictions and two plain history words.
    bit       mq[$];
    bit [3:0] m_spec = '0;
    bit [3:0] m_commit = '0;
    bit       m_recover = 1'b0;
    bit       m_cv = 1'b0;
    bit       m_co = 1'b0;

    always @(posedge clock or posedge init) begin
        bit ready;
        bit res;
        bit mis;
        if (init) begin
            mq.delete();
            m_spec = '0;
            m_commit = '0;
            m_recover = 1'b0;
            m_cv = 1'b0;
            m_co = 1'b0;
        end else begin
            ready = !m_recover && (mq.size() < 4);
            res   = res_valid && !m_recover && (mq.size() > 0);
            mis   = res && (mq[0] != res_outcome);
            m_cv  = res;
            m_co  = res_outcome;
            if (res) m_commit = {m_commit[2:0], res_outcome};
            if (mis) begin
                mq.delete();
                m_spec = m_commit;
                m_recover = 1'b1;
            end else begin
                m_recover = 1'b0;
                if (res) void'(mq.pop_front());
                if (pred_valid && ready) begin
                    mq.push_back(pred_taken);
                    m_spec = {m_spec[2:0], pred_taken};
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("m_spec_hist", 32'(spec_hist), 32'(m_spec));
        chk("m_commit_hist", 32'(commit_hist), 32'(m_commit));
        chk("m_in_flight", 32'(in_flight), 32'(mq.size()));
        chk("m_pred_ready", 32'(pred_ready), 32'(!m_recover && (mq.size() < 4)));
        chk("m_flush", 32'(flush), 32'(m_recover));
        chk("m_commit_valid", 32'(commit_valid), 32'(m_cv));
        if (m_cv) chk("m_commit_outcome", 32'(commit_outcome), 32'(m_co));
    end

    task automatic cyc(input logic pv, input logic pt, input logic rv, input logic ro);
        pred_valid  = pv;
        pred_taken  = pt;
        res_valid   = rv;
        res_outcome = ro;
        @(posedge clock);
        #1;
        pred_valid  = 1'b0;
        pred_taken  = 1'b0;
        res_valid   = 1'b0;
        res_outcome = 1'b0;
    endtask

    initial begin
        init = 1'b1;
        #14;
        // 1. reset values
        chk("rst_spec", 32'(spec_hist), 32'h0);
        chk("rst_commit", 32'(commit_hist), 32'h0);
        chk("rst_in_flight", 32'(in_flight), 32'h0);
        chk("rst_ready", 32'(pred_ready), 32'h1);
        chk("rst_flush", 32'(flush), 32'h0);
        #1;
        init = 1'b0;
        @(posedge clock);
        #1;

        // 2. push T,N,T then resolve 1,0,1 in order
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        chk("t2_spec", 32'(spec_hist), 32'h5);
        chk("t2_in_flight", 32'(in_flight), 32'h3);
        cyc(0, 0, 1, 1);
        chk("t2_cv0", 32'(commit_valid), 32'h1);
        chk("t2_co0", 32'(commit_outcome), 32'h1);
        cyc(0, 0, 1, 0);
        chk("t2_cv1", 32'(commit_valid), 32'h1);
        chk("t2_co1", 32'(commit_outcome), 32'h0);
        cyc(0, 0, 1, 1);
        chk("t2_co2", 32'(commit_outcome), 32'h1);
        chk("t2_commit", 32'(commit_hist), 32'h5);
        chk("t2_empty", 32'(in_flight), 32'h0);
        cyc(0, 0, 0, 0);
        chk("t2_cv_idle", 32'(commit_valid), 32'h0);

        // 3. five back-to-back pushes into a 4-deep queue
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
        chk("t3_ready_full", 32'(pred_ready), 32'h0);
        cyc(1, 1, 0, 0);
        chk("t3_spec", 32'(spec_hist), 32'hF);
        chk("t3_in_flight", 32'(in_flight), 32'h4);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1);
        chk("t3_drained", 32'(in_flight), 32'h0);
        chk("t3_commit", 32'(commit_hist), 32'hF);

        // 6b. asynchronous INIT with three branches in flight
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
        chk("t6_in_flight3", 32'(in_flight), 32'h3);
        init = 1'b1;
        #2;
        chk("t6_arst_spec", 32'(spec_hist), 32'h0);
        chk("t6_arst_commit", 32'(commit_hist), 32'h0);
        chk("t6_arst_in_flight", 32'(in_flight), 32'h0);
        chk("t6_arst_ready", 32'(pred_ready), 32'h1);
        chk("t6_arst_cv", 32'(commit_valid), 32'h0);
        init = 1'b0;
        @(posedge clock);
        #1;

        // 4. mispredict with a same-cycle push, then resolve attempt during recover
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
        chk("t4_spec_pre", 32'(spec_hist), 32'h7);
        cyc(1, 1, 1, 0);
        chk("t4_flush", 32'(flush), 32'h1);
        chk("t4_ready", 32'(pred_ready), 32'h0);
        chk("t4_spec", 32'(spec_hist), 32'h0);
        chk("t4_commit", 32'(commit_hist), 32'h0);
        chk("t4_in_flight", 32'(in_flight), 32'h0);
        cyc(1, 1, 1, 1);
        chk("t4_flush_off", 32'(flush), 32'h0);
        chk("t4_ready_back", 32'(pred_ready), 32'h1);
        chk("t4_recover_cv", 32'(commit_valid), 32'h0);
        chk("t4_recover_in_flight", 32'(in_flight), 32'h0);

        // 5. correct resolve plus push in the same cycle
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("t5_spec_pre", 32'(spec_hist), 32'h2);
        cyc(1, 1, 1, 1);
        chk("t5_in_flight_a", 32'(in_flight), 32'h2);
        chk("t5_spec_a", 32'(spec_hist), 32'h5);
        chk("t5_commit_a", 32'(commit_hist), 32'h1);
        cyc(1, 0, 1, 0);
        chk("t5_in_flight_b", 32'(in_flight), 32'h2);
        chk("t5_spec_b", 32'(spec_hist), 32'hA);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 0);
        chk("t5_commit", 32'(commit_hist), 32'hA);
        chk("t5_empty", 32'(in_flight), 32'h0);

        // 6a. resolve while empty is ignored
        cyc(0, 0, 1, 1);
        chk("t6_no_cv", 32'(commit_valid), 32'h0);
        chk("t6_commit", 32'(commit_hist), 32'hA);
        chk("t6_spec", 32'(spec_hist), 32'hA);

        // mispredict with a non-zero architectural history restores it into spec_hist
        cyc(1, 1, 0, 0);
        chk("t7_spec_pre", 32'(spec_hist), 32'h5);
        cyc(0, 0, 1, 0);
        chk("t7_commit", 32'(commit_hist), 32'h4);
        chk("t7_spec", 32'(spec_hist), 32'h4);
        chk("t7_flush", 32'(flush), 32'h1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
